// File: rtl/score_overlay_if.sv
// Pixel-path and game-event bundle between the game logic, the overlay stage and the VGA controller.
interface score_overlay_if;
  logic        hit;
  logic        miss;
  logic        clear;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic [23:0] rgb_in;
  logic [23:0] rgb_out;
  logic [3:0]  score;
  logic [1:0]  misses;
  logic        game_over;

  modport master (
    output hit, miss, clear, pixel_x, pixel_y, rgb_in,
    input  rgb_out, score, misses, game_over
  );

  modport slave (
    input  hit, miss, clear, pixel_x, pixel_y, rgb_in,
    output rgb_out, score, misses, game_over
  );
endinterface

// File: rtl/score_overlay.sv
// Hit/miss tally committed once per frame, drawn as box rows over the incoming pixel stream.
// state | meaning
// PLAY  | normal play, filled boxes drawn steadily
// BLINK | recent hit committed, filled score boxes blink while blink_cnt runs down
// OVER  | miss limit reached, events ignored, red frame drawn at screen edges
module score_overlay #(
  parameter int          V_ACTIVE     = 480,
  parameter int          H_ACTIVE     = 640,
  parameter int          MAX_SCORE    = 9,
  parameter int          MAX_MISSES   = 3,
  parameter int          BAR_X0       = 8,
  parameter int          BAR_Y0       = 8,
  parameter int          BOX_W        = 16,
  parameter int          BOX_H        = 16,
  parameter int          GAP          = 4,
  parameter int          BLINK_FRAMES = 60,
  parameter logic [23:0] C_HIT        = 24'h00FF00,
  parameter logic [23:0] C_MISS       = 24'hFF0000
) (
  input logic           clk,
  input logic           rst,
  score_overlay_if.slave bus
);

  localparam int EDGE    = 4;
  localparam int PITCH   = BOX_W + GAP;
  localparam int MISS_Y0 = BAR_Y0 + BOX_H + GAP;

  typedef enum logic [1:0] {PLAY, BLINK, OVER} state_t;

  state_t      state;
  logic        hit_q, miss_q;
  logic [1:0]  pend_hit, pend_miss;
  logic [3:0]  score;
  logic [1:0]  misses;
  logic [5:0]  blink_cnt;
  logic        game_over;

  logic        hit_ev, miss_ev, frame_tick;
  logic [4:0]  score_sum;
  logic [2:0]  miss_sum;
  logic [3:0]  score_next;
  logic [1:0]  misses_next;

  assign hit_ev      = bus.hit & ~hit_q;
  assign miss_ev     = bus.miss & ~miss_q;
  assign frame_tick  = (bus.pixel_x == 10'd0) && (bus.pixel_y == 10'(V_ACTIVE));
  assign score_sum   = {1'b0, score} + {3'b000, pend_hit};
  assign score_next  = (score_sum > 5'(MAX_SCORE)) ? 4'(MAX_SCORE) : score_sum[3:0];
  assign miss_sum    = {1'b0, misses} + {1'b0, pend_miss};
  assign misses_next = (miss_sum > 3'(MAX_MISSES)) ? 2'(MAX_MISSES) : miss_sum[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
      pend_hit  <= '0;
      pend_miss <= '0;
      score     <= '0;
      misses    <= '0;
      blink_cnt <= '0;
      state     <= PLAY;
      game_over <= 1'b0;
    end else begin
      hit_q  <= bus.hit;
      miss_q <= bus.miss;
      if (bus.clear) begin
        pend_hit  <= '0;
        pend_miss <= '0;
        score     <= '0;
        misses    <= '0;
        blink_cnt <= '0;
        state     <= PLAY;
        game_over <= 1'b0;
      end else if (frame_tick) begin
        // Events landing on the tick itself start the next frame's pending count.
        pend_hit  <= (hit_ev  && state != OVER) ? 2'd1 : 2'd0;
        pend_miss <= (miss_ev && state != OVER) ? 2'd1 : 2'd0;
        if (state != OVER) begin
          score  <= score_next;
          misses <= misses_next;
          if (misses_next == 2'(MAX_MISSES)) begin
            state     <= OVER;
            game_over <= 1'b1;
            blink_cnt <= '0;
          end else if (pend_hit != 2'd0) begin
            state     <= BLINK;
            blink_cnt <= 6'(BLINK_FRAMES - 1);
          end else if (state == BLINK) begin
            if (blink_cnt == 6'd0) state <= PLAY;
            else                   blink_cnt <= blink_cnt - 6'd1;
          end
        end
      end else if (state != OVER) begin
        if (hit_ev  && pend_hit  != 2'd3) pend_hit  <= pend_hit + 2'd1;
        if (miss_ev && pend_miss != 2'd3) pend_miss <= pend_miss + 2'd1;
      end
    end
  end

  logic        active, on_edge, in_score_row, in_miss_row, show_fill;
  logic [23:0] rgb;

  assign active       = (bus.pixel_x < 10'(H_ACTIVE)) && (bus.pixel_y < 10'(V_ACTIVE));
  assign on_edge      = (bus.pixel_x < 10'(EDGE)) || (bus.pixel_x >= 10'(H_ACTIVE - EDGE)) ||
                        (bus.pixel_y < 10'(EDGE)) || (bus.pixel_y >= 10'(V_ACTIVE - EDGE));
  assign in_score_row = (bus.pixel_y >= 10'(BAR_Y0)) && (bus.pixel_y < 10'(BAR_Y0 + BOX_H));
  assign in_miss_row  = (bus.pixel_y >= 10'(MISS_Y0)) && (bus.pixel_y < 10'(MISS_Y0 + BOX_H));
  assign show_fill    = (state != BLINK) || !blink_cnt[3];

  // Box extents are unrolled constants, so each box is a pair of compares.
  always_comb begin
    rgb = bus.rgb_in;
    for (int i = 0; i < MAX_SCORE; i++) begin
      if (in_score_row && show_fill && (5'(i) < {1'b0, score}) &&
          (bus.pixel_x >= 10'(BAR_X0 + i * PITCH)) &&
          (bus.pixel_x <  10'(BAR_X0 + i * PITCH + BOX_W)))
        rgb = C_HIT;
    end
    for (int j = 0; j < MAX_MISSES; j++) begin
      if (in_miss_row && (3'(j) < {1'b0, misses}) &&
          (bus.pixel_x >= 10'(BAR_X0 + j * PITCH)) &&
          (bus.pixel_x <  10'(BAR_X0 + j * PITCH + BOX_W)))
        rgb = C_MISS;
    end
    if (!active)
      rgb = '0;
    else if (state == OVER && on_edge)
      rgb = C_MISS;
  end

  assign bus.rgb_out   = rgb;
  assign bus.score     = score;
  assign bus.misses    = misses;
  assign bus.game_over = game_over;

endmodule

// File: tb/tb_score_overlay.sv
// Directed bench for score_overlay: frame-level tally model checked every cycle plus literal probes.
module tb_score_overlay;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  score_overlay_if bus();
  score_overlay dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec = 0;
  int n_bad = 0;

  // Frame-level model: tally, pending counts, game-over flag, frames since last blink start.
  int m_score = 0, m_misses = 0, m_ph = 0, m_pm = 0, m_age = -1;
  bit m_over = 0, m_phit = 0, m_pmiss = 0;
  int rise_h, rise_m;
  bit is_tick;

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [23:0] exp_rgb(int x, int y, logic [23:0] rin);
    bit show;
    show = (m_age < 0) || (((59 - m_age) / 8) % 2 == 0);
    if (x >= 640 || y >= 480) return 24'h0;
    if (m_over && (x < 4 || x >= 636 || y < 4 || y >= 476)) return 24'hFF0000;
    if (y >= 8 && y < 24 && x >= 8 && (x - 8) % 20 < 16 && (x - 8) / 20 < 9 &&
        (x - 8) / 20 < m_score && show) return 24'h00FF00;
    if (y >= 28 && y < 44 && x >= 8 && (x - 8) % 20 < 16 && (x - 8) / 20 < 3 &&
        (x - 8) / 20 < m_misses) return 24'hFF0000;
    return rin;
  endfunction

  always @(posedge clk) begin
    rise_h  = (bus.hit  && !m_phit)  ? 1 : 0;
    rise_m  = (bus.miss && !m_pmiss) ? 1 : 0;
    is_tick = (bus.pixel_x == 0) && (bus.pixel_y == 480);
    if (rst) begin
      m_score = 0; m_misses = 0; m_ph = 0; m_pm = 0; m_age = -1;
      m_over = 0; m_phit = 0; m_pmiss = 0;
    end else begin
      m_phit  = bus.hit;
      m_pmiss = bus.miss;
      if (bus.clear) begin
        m_score = 0; m_misses = 0; m_ph = 0; m_pm = 0; m_age = -1; m_over = 0;
      end else if (is_tick) begin
        if (!m_over) begin
          m_score  = imin(m_score + m_ph, 9);
          m_misses = imin(m_misses + m_pm, 3);
          if (m_misses == 3) begin
            m_over = 1; m_age = -1;
          end else if (m_ph > 0) begin
            m_age = 0;
          end else if (m_age >= 0) begin
            m_age++;
            if (m_age == 60) m_age = -1;
          end
          m_ph = rise_h; m_pm = rise_m;
        end else begin
          m_ph = 0; m_pm = 0;
        end
      end else if (!m_over) begin
        m_ph = imin(m_ph + rise_h, 3);
        m_pm = imin(m_pm + rise_m, 3);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %06h, expected %06h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("score",     int'(bus.score),     m_score);
      chk("misses",    int'(bus.misses),    m_misses);
      chk("game_over", int'(bus.game_over), int'(m_over));
      chk("rgb_out",   int'(bus.rgb_out),
          int'(exp_rgb(int'(bus.pixel_x), int'(bus.pixel_y), bus.rgb_in)));
    end
  end

  int px [20] = '{0, 8, 23, 24, 28, 168, 183, 184, 8, 50, 60, 639, 640, 3, 4, 636, 300, 300, 700, 0};
  int py [20] = '{0, 8, 23, 8, 8, 20, 23, 8, 28, 40, 43, 479, 0, 200, 200, 300, 476, 100, 100, 500};
  int pidx = 0;

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      cyc();
      bus.pixel_x = 10'(px[pidx]);
      bus.pixel_y = 10'(py[pidx]);
      pidx = (pidx + 1) % 20;
    end
  endtask

  task automatic tick();
    cyc(); bus.pixel_x = 10'd0;   bus.pixel_y = 10'd480;
    cyc(); bus.pixel_x = 10'd700; bus.pixel_y = 10'd100;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      idle(2);
    end
  endtask

  task automatic pulse_hit();
    cyc(); bus.hit = 1'b1;
    cyc(); bus.hit = 1'b0;
  endtask

  task automatic pulse_miss();
    cyc(); bus.miss = 1'b1;
    cyc(); bus.miss = 1'b0;
  endtask

  task automatic do_clear();
    cyc(); bus.clear = 1'b1;
    cyc(); bus.clear = 1'b0;
  endtask

  task automatic probe(input string name, input int x, input int y, input int exp);
    bus.pixel_x = 10'(x);
    bus.pixel_y = 10'(y);
    #1;
    chk(name, int'(bus.rgb_out), exp);
  endtask

  initial begin
    rst = 1'b1;
    bus.hit = 1'b0; bus.miss = 1'b0; bus.clear = 1'b0;
    bus.pixel_x = 10'd700; bus.pixel_y = 10'd100;
    bus.rgb_in = 24'h123456;
    idle(4);
    rst = 1'b0;

    // Reset state and pass-through across two frames
    idle(20);
    chk("t1_score", int'(bus.score), 0);
    chk("t1_go", int'(bus.game_over), 0);
    probe("t1_active", 100, 100, 24'h123456);
    probe("t1_box0_empty", 8, 8, 24'h123456);
    probe("t1_hblank", 700, 10, 0);
    probe("t1_vblank", 10, 490, 0);
    ticks(2);

    // Held hit counts once, commits on tick, then blinks for 60 frames
    cyc(); bus.hit = 1'b1;
    idle(100);
    bus.hit = 1'b0;
    chk("t2_score_pre", int'(bus.score), 0);
    tick();
    chk("t2_score_post", int'(bus.score), 1);
    probe("t2_blink_hidden", 8, 8, 24'h123456);
    ticks(4);
    probe("t2_box0_shown", 23, 23, 24'h00FF00);
    probe("t2_gap", 24, 8, 24'h123456);
    probe("t2_missrow_empty", 8, 28, 24'h123456);
    ticks(44);
    probe("t2_blink_hidden2", 8, 8, 24'h123456);
    ticks(12);
    probe("t2_play_shown", 8, 8, 24'h00FF00);
    ticks(10);
    probe("t2_play_steady", 8, 8, 24'h00FF00);

    // Simultaneous hit+miss, then pending hits saturate at 3
    do_clear();
    cyc(); bus.hit = 1'b1; bus.miss = 1'b1;
    cyc(); bus.hit = 1'b0; bus.miss = 1'b0;
    pulse_hit(); pulse_hit(); pulse_hit();
    tick();
    chk("t3_score", int'(bus.score), 3);
    chk("t3_misses", int'(bus.misses), 1);
    probe("t3_missbox0", 8, 28, 24'hFF0000);
    probe("t3_missbox1_empty", 28, 28, 24'h123456);
    idle(5);

    // Three misses end the game; later hits are ignored
    do_clear();
    for (int k = 1; k <= 3; k++) begin
      pulse_miss();
      tick();
      chk("t4_misses", int'(bus.misses), k);
      chk("t4_go", int'(bus.game_over), (k == 3) ? 1 : 0);
    end
    probe("t4_edge_tl", 0, 0, 24'hFF0000);
    probe("t4_edge_br", 639, 479, 24'hFF0000);
    probe("t4_inner", 4, 4, 24'h123456);
    pulse_hit();
    tick();
    idle(3);
    chk("t4_score_frozen", int'(bus.score), 0);

    // Score saturates at 9
    do_clear();
    chk("t5_go_cleared", int'(bus.game_over), 0);
    for (int f = 1; f <= 3; f++) begin
      pulse_hit(); pulse_hit(); pulse_hit();
      tick();
      chk("t5_score", int'(bus.score), 3 * f);
    end
    pulse_hit(); pulse_hit();
    tick();
    chk("t5_score_sat", int'(bus.score), 9);
    ticks(4);
    probe("t5_box8", 183, 23, 24'h00FF00);
    probe("t5_past_box8", 184, 8, 24'h123456);

    // clear beats a coincident tick with a hit pending
    pulse_miss();
    tick();
    chk("t6_misses_pre", int'(bus.misses), 1);
    pulse_hit();
    cyc(); bus.clear = 1'b1; bus.pixel_x = 10'd0; bus.pixel_y = 10'd480;
    cyc(); bus.clear = 1'b0; bus.pixel_x = 10'd700; bus.pixel_y = 10'd100;
    chk("t6_score", int'(bus.score), 0);
    chk("t6_misses", int'(bus.misses), 0);
    chk("t6_go", int'(bus.game_over), 0);
    tick();
    chk("t6_score_after_tick", int'(bus.score), 0);
    probe("t6_box0_empty", 8, 8, 24'h123456);
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
